// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle controller for an external combinational ALU. One register-to-
// register command is accepted in WAIT, then the block walks through
// RD_A -> RD_B -> EXEC -> WB, reading operands from an 8x16 register file,
// presenting them to the ALU, capturing result/Z and writing back.
module alu_op_sequencer #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [2:0]  cmd,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [7:0]  imm8,
    output logic        w,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_z,
    output logic        z_flag,
    input  logic [2:0]  rdaddr,
    output logic [15:0] rddata
);

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_AND  = 3'b010;
    localparam logic [2:0] CMD_MVN  = 3'b011;
    localparam logic [2:0] CMD_CMP  = 3'b100;
    localparam logic [2:0] CMD_MOVI = 3'b101;
    localparam logic [2:0] CMD_MOV  = 3'b110;
    localparam logic [2:0] CMD_NOP  = 3'b111;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_NOTB = 2'b11;

    state_t      state_r;
    state_t      state_n_s;
    logic        w_r;
    logic [2:0]  cmd_r;
    logic [2:0]  rd_r;
    logic [2:0]  rn_r;
    logic [2:0]  rm_r;
    logic [7:0]  imm_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [15:0] c_r;
    logic [1:0]  op_r;
    logic        z_r;
    logic [15:0] regs_r [NREGS];
    logic [15:0] imm_sext_s;
    logic        accept_s;

    // ALU opcode for a command; MOV is add-with-zero, MOVI/NOP are don't-care adds
    function automatic logic [1:0] decode_op(input logic [2:0] c);
        logic [1:0] op;
        case (c)
            CMD_ADD: op = OP_ADD;
            CMD_SUB: op = OP_SUB;
            CMD_CMP: op = OP_SUB;
            CMD_AND: op = OP_AND;
            CMD_MVN: op = OP_NOTB;
            CMD_MOV: op = OP_ADD;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // Commands whose ALU result is written back to R[rd]
    function automatic logic writes_result(input logic [2:0] c);
        logic wr;
        case (c)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_MVN, CMD_MOV: wr = 1'b1;
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

    // Commands that update the Z status flag
    function automatic logic updates_z(input logic [2:0] c);
        logic uz;
        case (c)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_MVN, CMD_CMP: uz = 1'b1;
            default: uz = 1'b0;
        endcase
        return uz;
    endfunction

    assign accept_s   = (state_r == ST_WAIT) && s;
    assign imm_sext_s = {{8{imm_r[7]}}, imm_r};

    assign w      = w_r;
    assign alu_a  = a_r;
    assign alu_b  = b_r;
    assign alu_op = op_r;
    assign z_flag = z_r;
    assign rddata = regs_r[rdaddr];

    // Next-state logic: fixed one-cycle-per-state walk once a command is accepted
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (s) begin
                    state_n_s = ST_RD_A;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_RD_A: state_n_s = ST_RD_B;
            ST_RD_B: state_n_s = ST_EXEC;
            ST_EXEC: state_n_s = ST_WB;
            ST_WB:   state_n_s = ST_WAIT;
            default: state_n_s = ST_WAIT;
        endcase
    end

    // State register and registered ready flag (high exactly while in WAIT)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_WAIT;
            w_r     <= 1'b1;
        end else begin
            state_r <= state_n_s;
            w_r     <= (state_n_s == ST_WAIT);
        end
    end

    // Command latch: fields are captured only when a command is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_r <= CMD_NOP;
            rd_r  <= 3'd0;
            rn_r  <= 3'd0;
            rm_r  <= 3'd0;
            imm_r <= 8'd0;
        end else if (accept_s) begin
            cmd_r <= cmd;
            rd_r  <= rd;
            rn_r  <= rn;
            rm_r  <= rm;
            imm_r <= imm8;
        end else begin
            cmd_r <= cmd_r;
            rd_r  <= rd_r;
            rn_r  <= rn_r;
            rm_r  <= rm_r;
            imm_r <= imm_r;
        end
    end

    // Operand/result datapath: A in RD_A, B and ALU op in RD_B, C and Z in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r  <= 16'd0;
            b_r  <= 16'd0;
            c_r  <= 16'd0;
            op_r <= OP_ADD;
            z_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RD_A: begin
                    // MOV is performed as 0 + R[rm]
                    if (cmd_r == CMD_MOV) begin
                        a_r <= 16'd0;
                    end else begin
                        a_r <= regs_r[rn_r];
                    end
                end
                ST_RD_B: begin
                    b_r  <= regs_r[rm_r];
                    op_r <= decode_op(cmd_r);
                end
                ST_EXEC: begin
                    c_r <= alu_out;
                    if (updates_z(cmd_r)) begin
                        z_r <= alu_z;
                    end else begin
                        z_r <= z_r;
                    end
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    // Register file write-back in WB; reset clears every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 16'd0;
            end
        end else if (state_r == ST_WB) begin
            if (writes_result(cmd_r)) begin
                regs_r[rd_r] <= c_r;
            end else if (cmd_r == CMD_MOVI) begin
                regs_r[rd_r] <= imm_sext_s;
            end else begin
                regs_r[rd_r] <= regs_r[rd_r];
            end
        end else begin
            regs_r[rd_r] <= regs_r[rd_r];
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random
// commands checked against a command-level register-file model.
module tb_alu_op_sequencer;

    localparam logic [2:0] C_ADD  = 3'b000;
    localparam logic [2:0] C_SUB  = 3'b001;
    localparam logic [2:0] C_AND  = 3'b010;
    localparam logic [2:0] C_MVN  = 3'b011;
    localparam logic [2:0] C_CMP  = 3'b100;
    localparam logic [2:0] C_MOVI = 3'b101;
    localparam logic [2:0] C_MOV  = 3'b110;
    localparam logic [2:0] C_NOP  = 3'b111;

    logic        clk;
    logic        reset;
    logic        s;
    logic [2:0]  cmd;
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [7:0]  imm8;
    logic        w;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        z_flag;
    logic [2:0]  rdaddr;
    logic [15:0] rddata;

    int checks;
    int failures;

    logic [15:0] m_regs [8];
    logic        m_z;

    alu_op_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .cmd    (cmd),
        .rd     (rd),
        .rn     (rn),
        .rm     (rm),
        .imm8   (imm8),
        .w      (w),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_out(alu_out),
        .alu_z  (alu_z),
        .z_flag (z_flag),
        .rdaddr (rdaddr),
        .rddata (rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The standalone ALU the sequencer drives
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            2'b10:   alu_out = alu_a & alu_b;
            2'b11:   alu_out = ~alu_b;
            default: alu_out = 16'h0000;
        endcase
    end
    assign alu_z = (alu_out == 16'h0000);

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_z = 1'b0;
    endtask

    // Issue one command, check handshake/ALU drive, then the architectural result
    task automatic run_cmd(input logic [2:0] c, input logic [2:0] d, input logic [2:0] n,
                           input logic [2:0] m, input logic [7:0] i, input bit noisy);
        logic [15:0] va, vb, ea, res;
        logic [1:0]  eop;
        bit          wr, upz;
        int          waited;
        waited = 0;
        while (w !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (w !== 1'b1) begin
            failures++;
            $display("FAIL ready: w=%b expected 1", w);
        end
        va = m_regs[n];
        vb = m_regs[m];
        ea = va;
        eop = 2'b00;
        wr = 1'b1;
        upz = 1'b1;
        case (c)
            C_ADD:  res = va + vb;
            C_SUB:  begin res = va - vb; eop = 2'b01; end
            C_AND:  begin res = va & vb; eop = 2'b10; end
            C_MVN:  begin res = ~vb; eop = 2'b11; end
            C_CMP:  begin res = va - vb; eop = 2'b01; wr = 1'b0; end
            C_MOVI: begin res = 16'($signed(i)); upz = 1'b0; end
            C_MOV:  begin res = vb; ea = 16'h0000; upz = 1'b0; end
            default: begin res = 16'h0000; wr = 1'b0; upz = 1'b0; end
        endcase
        s = 1'b1; cmd = c; rd = d; rn = n; rm = m; imm8 = i;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w !== 1'b0) begin
                failures++;
                $display("FAIL busy_w cmd=%0d phase=%0d: w=%b expected 0", c, k, w);
            end
            if (k == 2) begin
                checks++;
                if (alu_a !== ea || alu_b !== vb || alu_op !== eop) begin
                    failures++;
                    $display("FAIL exec_drive cmd=%0d: a=%h b=%h op=%b expected a=%h b=%h op=%b",
                             c, alu_a, alu_b, alu_op, ea, vb, eop);
                end
            end
            s    = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
            cmd  = 3'($urandom_range(7, 0));
            rd   = 3'($urandom_range(7, 0));
            rn   = 3'($urandom_range(7, 0));
            rm   = 3'($urandom_range(7, 0));
            imm8 = 8'($urandom_range(255, 0));
            @(negedge clk);
        end
        s = 1'b0;
        checks++;
        if (w !== 1'b1) begin
            failures++;
            $display("FAIL w_return cmd=%0d: w=%b expected 1", c, w);
        end
        if (wr) m_regs[d] = res;
        if (upz) m_z = (res == 16'h0000);
        checks++;
        if (z_flag !== m_z) begin
            failures++;
            $display("FAIL z_flag cmd=%0d: got %b expected %b", c, z_flag, m_z);
        end
        rdaddr = d;
        #1;
        checks++;
        if (rddata !== m_regs[d]) begin
            failures++;
            $display("FAIL writeback cmd=%0d R%0d: got %h expected %h", c, d, rddata, m_regs[d]);
        end
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rdaddr = 3'(i);
            #1;
            checks++;
            if (rddata !== m_regs[i]) begin
                failures++;
                $display("FAIL regfile R%0d: got %h expected %h", i, rddata, m_regs[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s = 1'b0; cmd = C_NOP; rd = 3'd0; rn = 3'd0; rm = 3'd0;
        imm8 = 8'h00; rdaddr = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (w !== 1'b1 || alu_a !== 16'h0000 || alu_b !== 16'h0000 ||
            alu_op !== 2'b00 || z_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: w=%b a=%h b=%h op=%b z=%b expected 1 0000 0000 00 0",
                     w, alu_a, alu_b, alu_op, z_flag);
        end
        reset = 1'b0;
        model_clear();
        check_all_regs();
    endtask

    task automatic test_movi_add();
        run_cmd(C_MOVI, 3'd0, 3'd0, 3'd0, 8'd5, 1'b0);
        run_cmd(C_MOVI, 3'd1, 3'd0, 3'd0, 8'hFD, 1'b0);
        rdaddr = 3'd1; #1;
        checks++;
        if (rddata !== 16'hFFFD || z_flag !== 1'b0) begin
            failures++;
            $display("FAIL movi_neg: R1=%h z=%b expected fffd 0", rddata, z_flag);
        end
        run_cmd(C_ADD, 3'd2, 3'd0, 3'd1, 8'h00, 1'b0);
        rdaddr = 3'd2; #1;
        checks++;
        if (rddata !== 16'h0002 || z_flag !== 1'b0) begin
            failures++;
            $display("FAIL add_basic: R2=%h z=%b expected 0002 0", rddata, z_flag);
        end
    endtask

    task automatic test_cmp_sub();
        run_cmd(C_CMP, 3'd7, 3'd0, 3'd0, 8'h00, 1'b0);
        checks++;
        if (z_flag !== 1'b1) begin
            failures++;
            $display("FAIL cmp_equal: z=%b expected 1", z_flag);
        end
        run_cmd(C_SUB, 3'd3, 3'd1, 3'd0, 8'h00, 1'b0);
        rdaddr = 3'd3; #1;
        checks++;
        if (rddata !== 16'hFFF8 || z_flag !== 1'b0) begin
            failures++;
            $display("FAIL sub_basic: R3=%h z=%b expected fff8 0", rddata, z_flag);
        end
    endtask

    task automatic test_logic();
        run_cmd(C_MVN, 3'd4, 3'd0, 3'd0, 8'h00, 1'b0);
        run_cmd(C_AND, 3'd5, 3'd4, 3'd1, 8'h00, 1'b0);
        rdaddr = 3'd5; #1;
        checks++;
        if (rddata !== 16'hFFF8) begin
            failures++;
            $display("FAIL and_basic: R5=%h expected fff8", rddata);
        end
        run_cmd(C_CMP, 3'd0, 3'd2, 3'd2, 8'h00, 1'b0);
        run_cmd(C_MOV, 3'd6, 3'd3, 3'd5, 8'h00, 1'b0);
        rdaddr = 3'd6; #1;
        checks++;
        if (rddata !== 16'hFFF8 || z_flag !== 1'b1) begin
            failures++;
            $display("FAIL mov_keeps_z: R6=%h z=%b expected fff8 1", rddata, z_flag);
        end
    endtask

    task automatic test_wrap();
        run_cmd(C_MOVI, 3'd0, 3'd0, 3'd0, 8'd127, 1'b0);
        for (int k = 0; k < 7; k++) run_cmd(C_ADD, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0);
        rdaddr = 3'd0; #1;
        checks++;
        if (rddata !== 16'h3F80) begin
            failures++;
            $display("FAIL add_chain: R0=%h expected 3f80", rddata);
        end
        run_cmd(C_MOVI, 3'd1, 3'd0, 3'd0, 8'h80, 1'b0);
        for (int k = 0; k < 8; k++) run_cmd(C_ADD, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0);
        run_cmd(C_ADD, 3'd2, 3'd1, 3'd1, 8'h00, 1'b0);
        rdaddr = 3'd2; #1;
        checks++;
        if (rddata !== 16'h0000 || z_flag !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap: R2=%h z=%b expected 0000 1", rddata, z_flag);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(C_MOVI, 3'd1, 3'd0, 3'd0, 8'd3, 1'b0);
        run_cmd(C_ADD, 3'd2, 3'd1, 3'd1, 8'h00, 1'b0);
        run_cmd(C_ADD, 3'd2, 3'd2, 3'd1, 8'h00, 1'b0);
        rdaddr = 3'd2; #1;
        checks++;
        if (rddata !== 16'h0009) begin
            failures++;
            $display("FAIL back_to_back: R2=%h expected 0009", rddata);
        end
    endtask

    task automatic test_noisy();
        run_cmd(C_MOVI, 3'd3, 3'd0, 3'd0, 8'd9, 1'b1);
        run_cmd(C_SUB, 3'd4, 3'd3, 3'd1, 8'h00, 1'b1);
        run_cmd(C_NOP, 3'd5, 3'd3, 3'd3, 8'h77, 1'b1);
        rdaddr = 3'd4; #1;
        checks++;
        if (rddata !== 16'h0006) begin
            failures++;
            $display("FAIL noisy_inputs: R4=%h expected 0006", rddata);
        end
        check_all_regs();
    endtask

    task automatic test_reset_mid();
        run_cmd(C_MOVI, 3'd7, 3'd0, 3'd0, 8'h55, 1'b0);
        s = 1'b1; cmd = C_ADD; rd = 3'd7; rn = 3'd7; rm = 3'd3;
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (w !== 1'b0) begin
            failures++;
            $display("FAIL exec_busy: w=%b expected 0", w);
        end
        #1 reset = 1'b1;
        #1;
        rdaddr = 3'd7;
        #1;
        checks++;
        if (w !== 1'b1 || rddata !== 16'h0000 || alu_a !== 16'h0000 || z_flag !== 1'b0) begin
            failures++;
            $display("FAIL async_abort: w=%b R7=%h a=%h z=%b expected 1 0000 0000 0",
                     w, rddata, alu_a, z_flag);
        end
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (w !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle: w=%b expected 1", w);
        end
        check_all_regs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_cmd(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                    3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                    8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
        end
        check_all_regs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_movi_add();
        test_cmp_sub();
        test_logic();
        test_wrap();
        test_back_to_back();
        test_noisy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
